mask_morph_3x3: RTL and testbench
=================================

Name: mask_morph_3x3

Overview:
- Streaming 3x3 binary morphology stage placed directly downstream of background_model_impl.
- It cleans the foreground or movement mask (all-ones/all-zeros 24-bit pixels) before blob extraction or overlay.
- It applies one of four operations per frame: pass, erode, dilate or majority (median of 9).
- It uses two line buffers, a 3x3 window, and a valid/ready stream with start-of-frame (tuser) and end-of-line (tlast).

Parameters:
- TDATA_WIDTH, 24, pixel width on both streams. The mask bit is the MSB.
- MAX_WIDTH, 1280, maximum line length in pixels. Sets line-buffer depth and column counter width (clog2).

Ports:
- clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_tdata  in  TDATA_WIDTH  input mask pixel; only bit TDATA_WIDTH-1 is used
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input beat accepted
- s_tuser  in  1  start of frame; first pixel of the frame
- s_tlast  in  1  last pixel of a line
- m_tdata  out  TDATA_WIDTH  filtered pixel, all ones or all zeros
- m_tvalid  out  1  output beat valid
- m_tready  in  1  downstream ready
- m_tuser  out  1  start of frame, aligned with its pixel
- m_tlast  out  1  end of line, aligned with its pixel
- mode  in  2  0 pass, 1 erode, 2 dilate, 3 majority
- line_err  out  1  sticky line-length error; cleared at the next accepted SOF

Behaviour:
- Reset (aresetn=0 at a clk edge):
  - m_tvalid, m_tuser, m_tlast, m_tdata, line_err = 0.
  - Column counter, row counter, window registers and learned line length = 0.
  - State = WAIT_SOF.
  - Line-buffer RAM contents need not be cleared.
- Handshake:
  - Pipeline enable is ce = !(m_tvalid && !m_tready); s_tready = ce.
  - An input beat is accepted when s_tvalid && s_tready.
  - m_* hold stable while m_tvalid && !m_tready.
- Latency: 2 ce-cycles from the accepted input beat to the corresponding m_tvalid beat. Stage 1 reads the line buffers and shifts the window; stage 2 evaluates the operation and registers the output.
- Exactly one output beat is produced per accepted in-frame input beat.
- States:
  - WAIT_SOF: accept and discard beats with no output until a beat has s_tuser=1, then go to RUN with col=0, row=0.
  - RUN: process beats. A beat with s_tuser=1 restarts the frame: col=0, row=0, line_err cleared, mode re-latched.
- Geometry:
  - The window's bottom-right pixel is the current input pixel (row r, column c).
  - The result is emitted on that beat's tuser/tlast. The output image is therefore the filtered image translated by (+1,+1).
  - Rows r-2 and r-1 come from two MAX_WIDTH x 1 bit line buffers, addressed by col.
  - The write happens on acceptance (read-before-write at the same address).
- Out-of-frame neighbours (row<2 or col<2 positions of the window):
  - Erode: treated as 1.
  - Dilate and majority: treated as 0.
  - Pass: ignored.
- Operations on the 9 window bits:
  - Pass outputs the current pixel.
  - Erode outputs the AND of the 9 bits.
  - Dilate outputs the OR of the 9 bits.
  - Majority outputs popcount >= 5 (4-bit popcount).
- Output pixel = {TDATA_WIDTH{result}}.
- mode is latched on the SOF beat; changes mid-frame take effect at the next SOF.
- Line length:
  - The first line's tlast column+1 is learned as the frame width.
  - On a later line, if tlast arrives at a different column, or col reaches the learned width-1 without tlast, line_err is set.
  - col and row follow the received tlast regardless of the error.
- MAX_WIDTH overflow: if col reaches MAX_WIDTH-1 without tlast, set line_err and wrap col to 0 with row+1.
- Simultaneous tuser and tlast on one beat is legal (a 1-pixel line).
- Reset mid-frame: state returns to WAIT_SOF. Remaining beats of the frame are dropped, and any output in flight is discarded.

Decomposition:
- Shared package (bgm_pkg):
  - MODE_PASS/ERODE/DILATE/MAJORITY constants.
  - MAJORITY_TH = 5.
  - State encodings WAIT_SOF/RUN.
- Natural sub-module: mask_line_buffer, a single-port-read/write 1-bit RAM of depth MAX_WIDTH with registered read and a ce input. Instantiate it twice, chained: line 1 output feeds line 2 input.

Test Plan:
- Pass mode, 8x4 frame with a checkerboard, m_tready=1 → output equals input.
  - Output appears 2 cycles after each input.
  - tuser on beat 0; tlast on beats 7,15,23,31.
  - line_err=0.
- Erode, 8x8 frame with a single 1 at (4,4) → all outputs 0.
- Dilate, same frame → output 1 exactly at window-bottom-right positions (4..6,4..6); 9 ones in total.
- Majority, 8x8 with a 3x3 solid block at (2..4,2..4) plus isolated 1s at (0,7) and (7,0):
  - Isolated pixels are removed.
  - The block yields 1 where popcount>=5 (the block centre maps to output (4,4)).
- Backpressure: m_tready toggles 1,0,0,1 repeatedly during the dilate test → identical output sequence, no dropped or duplicated beats, m_* stable while stalled.
- Errors and reset:
  - Second line tlast at column 5 of an 8-wide frame → line_err=1 until the next SOF.
  - aresetn=0 mid-frame, then data without tuser → no m_tvalid until the next tuser beat.

Source files
------------

// File: rtl/bgm_pkg.sv
// Shared constants for the mask morphology stage: operation codes, majority threshold, FSM states.
package bgm_pkg;
  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_ERODE    = 2'd1;
  localparam logic [1:0] MODE_DILATE   = 2'd2;
  localparam logic [1:0] MODE_MAJORITY = 2'd3;
  localparam int         MAJORITY_TH   = 5;

  typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/mask_line_buffer.sv
// One-bit line memory, one read port and one write port, registered read, read-before-write.
module mask_line_buffer #(
  parameter int DEPTH = 1280,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] raddr,
  input  logic [AW-1:0] waddr,
  input  logic          wd,
  output logic          q
);
  logic mem [DEPTH];

  always_ff @(posedge clk)
    if (ce && we) mem[waddr] <= wd;

  always_ff @(posedge clk)
    if (!aresetn) q <= 1'b0;
    else if (ce)  q <= mem[raddr];
endmodule

// File: rtl/mask_morph_3x3.sv
// Streaming 3x3 binary erode/dilate/majority on a 1-bit mask carried in the MSB of each pixel.
module mask_morph_3x3 import bgm_pkg::*; #(
  parameter int TDATA_WIDTH = 24,
  parameter int MAX_WIDTH   = 1280
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tuser,
  input  logic                   s_tlast,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tuser,
  output logic                   m_tlast,
  input  logic [1:0]             mode,
  output logic                   line_err
);
  localparam int CW = $clog2(MAX_WIDTH);

  state_t          state, state_nx;
  logic            ce, acc, sof, take, pix, err_set, res;
  logic [CW-1:0]   col, pc, col_d;
  logic [CW:0]     width, pc_inc;
  logic [1:0]      row, pr, mode_q, s1_mode;
  logic            q1, q2, q1_hold, byp_q, top_right;
  logic [1:0]      t_w, m_w;
  logic [2:0]      b_w;
  logic            rv_top, rv_mid, cv_l, cv_m, s1_user, s1_last;
  logic [2:1]      vld_pipe;
  logic [8:0]      win, vmask;
  logic            unused_lsbs;

  assign unused_lsbs = ^s_tdata[TDATA_WIDTH-2:0];
  assign pix      = s_tdata[TDATA_WIDTH-1];
  assign m_tvalid = vld_pipe[2];
  assign ce       = !(vld_pipe[2] && !m_tready);
  assign s_tready = ce;
  assign acc      = s_tvalid && ce;
  assign sof      = acc && s_tuser;

  always_ff @(posedge clk)
    if (!aresetn) state <= WAIT_SOF;
    else          state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == WAIT_SOF && sof) state_nx = RUN;
  end

  always_comb take = acc && (state == RUN || s_tuser);

  // An SOF beat is pixel (0,0) regardless of where the counters were.
  assign pc     = sof ? '0 : col;
  assign pr     = sof ? 2'd0 : row;
  assign pc_inc = {1'b0, pc} + {{CW{1'b0}}, 1'b1};
  assign err_set = (pr != 2'd0 && (s_tlast ? (pc_inc != width) : (pc_inc == width))) ||
                   (!s_tlast && pc == CW'(MAX_WIDTH-1));

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      col <= '0; row <= '0; width <= '0; mode_q <= MODE_PASS; line_err <= 1'b0; col_d <= '0;
    end else if (take) begin
      col_d <= pc;
      if (sof) mode_q <= mode;
      if (s_tlast || pc == CW'(MAX_WIDTH-1)) begin
        col <= '0;
        row <= (pr == 2'd2) ? 2'd2 : pr + 2'd1;
      end else begin
        col <= pc + CW'(1);
        row <= pr;
      end
      if (pr == 2'd0 && s_tlast) width <= pc_inc;
      line_err <= err_set || (line_err && !sof);
    end
  end

  // Line 2 is fed from line 1's registered read, so its write trails by one beat at col_d.
  mask_line_buffer #(.DEPTH(MAX_WIDTH), .AW(CW)) u_line1 (
    .clk(clk), .aresetn(aresetn), .ce(take), .we(1'b1),
    .raddr(pc), .waddr(pc), .wd(pix), .q(q1));
  mask_line_buffer #(.DEPTH(MAX_WIDTH), .AW(CW)) u_line2 (
    .clk(clk), .aresetn(aresetn), .ce(take), .we(1'b1),
    .raddr(pc), .waddr(col_d), .wd(q1), .q(q2));

  // On 1-pixel lines the trailing write hits the address being read; forward it.
  assign top_right = byp_q ? q1_hold : q2;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld_pipe[1] <= 1'b0;
      t_w <= '0; m_w <= '0; b_w <= '0; q1_hold <= 1'b0; byp_q <= 1'b0;
      rv_top <= 1'b0; rv_mid <= 1'b0; cv_l <= 1'b0; cv_m <= 1'b0;
      s1_user <= 1'b0; s1_last <= 1'b0; s1_mode <= MODE_PASS;
    end else if (ce) begin
      vld_pipe[1] <= take;
      if (take) begin
        t_w     <= {t_w[0], top_right};
        m_w     <= {m_w[0], q1};
        b_w     <= {b_w[1:0], pix};
        q1_hold <= q1;
        byp_q   <= (col_d == pc);
        rv_top  <= (pr == 2'd2);
        rv_mid  <= (pr != 2'd0);
        cv_l    <= (pc > CW'(1));
        cv_m    <= (pc != '0);
        s1_user <= s_tuser;
        s1_last <= s_tlast;
        s1_mode <= sof ? mode : mode_q;
      end
    end
  end

  assign win   = {t_w[1], t_w[0], top_right, m_w[1], m_w[0], q1, b_w[2], b_w[1], b_w[0]};
  assign vmask = {rv_top & cv_l, rv_top & cv_m, rv_top,
                  rv_mid & cv_l, rv_mid & cv_m, rv_mid, cv_l, cv_m, 1'b1};

  always_comb begin
    res = b_w[0];
    case (s1_mode)
      MODE_ERODE:    res = &(win | ~vmask);
      MODE_DILATE:   res = |(win & vmask);
      MODE_MAJORITY: res = popcount9(win & vmask) >= 4'(MAJORITY_TH);
      default:       res = b_w[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld_pipe[2] <= 1'b0; m_tdata <= '0; m_tuser <= 1'b0; m_tlast <= 1'b0;
    end else if (ce) begin
      vld_pipe[2] <= vld_pipe[1];
      m_tdata     <= {TDATA_WIDTH{res & vld_pipe[1]}};
      m_tuser     <= s1_user & vld_pipe[1];
      m_tlast     <= s1_last & vld_pipe[1];
    end
  end
endmodule

// File: tb/tb_mask_morph_3x3.sv
// Random and directed frames against an image-level morphology model with a beat scoreboard.
`timescale 1ns/1ps
module tb_mask_morph_3x3;
  localparam int TW = 24, MW = 16;

  logic          clk = 1'b0, aresetn = 1'b0;
  logic [TW-1:0] s_tdata = '0, m_tdata;
  logic          s_tvalid = 1'b0, s_tready, s_tuser = 1'b0, s_tlast = 1'b0;
  logic          m_tvalid, m_tready = 1'b1, m_tuser, m_tlast, line_err;
  logic [1:0]    mode = 2'd0;

  always #5 clk = ~clk;

  mask_morph_3x3 #(.TDATA_WIDTH(TW), .MAX_WIDTH(MW)) dut (
    .clk(clk), .aresetn(aresetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tuser(m_tuser), .m_tlast(m_tlast), .mode(mode), .line_err(line_err));

  typedef struct packed {logic px; logic u; logic l;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  bit   img [0:15][0:15];
  int   total = 0, bad = 0, out_cnt = 0, ones = 0, cnt0, rdy_mode = 0, ph = 0;
  bit   lat_arm = 0, st_prev = 0;
  time  t_sof;
  logic [26:0] prev_b;
  bit   pat [4] = '{1, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: 3x3 window ending at (r,c); out-of-frame taps are 1 for erode, 0 otherwise.
  function automatic bit ref_px(input int r, input int c, input int md);
    int n = 0; bit a = 1, o = 0, b;
    if (md == 0) return img[r][c];
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        int rr = r - 2 + dr, cc = c - 2 + dc;
        b = (rr < 0 || cc < 0) ? (md == 1) : img[rr][cc];
        a &= b; o |= b; n += b;
      end
    return (md == 1) ? a : (md == 2) ? o : (n >= 5);
  endfunction

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1:       begin m_tready = pat[ph % 4]; ph++; end
      2:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (aresetn && st_prev)
      chk("stall_hold", {5'd0, m_tvalid, m_tuser, m_tlast, m_tdata}, {5'd0, prev_b});
    if (aresetn && m_tvalid && m_tready) begin
      out_cnt++;
      if (m_tdata[TW-1]) ones++;
      if (q.size() == 0) chk("spurious_beat", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("out_beat", {6'd0, m_tdata, m_tuser, m_tlast}, {6'd0, {TW{mon_e.px}}, mon_e.u, mon_e.l});
        if (lat_arm && mon_e.u) begin
          chk("sof_latency", 32'($time - t_sof), 15);
          lat_arm = 0;
        end
      end
    end
    st_prev = aresetn && m_tvalid && !m_tready;
    prev_b  = {m_tvalid, m_tuser, m_tlast, m_tdata};
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input bit px, input bit u, input bit l, input bit ex, input bit push);
    bit ok = 0;
    s_tdata = {TW{px}}; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (s_tready) ok = 1;
      @(posedge clk);
    end
    if (ok && push) begin
      q.push_back('{px: ex, u: u, l: l});
      if (u) t_sof = $time;
    end
    #1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input int w, input int h, input int md, input int gapmax, input int lim);
    int n = 0;
    mode = 2'(md);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (lim >= 0 && n >= lim) return;
        idle($urandom_range(0, gapmax));
        beat(img[r][c], (r == 0 && c == 0), (c == w - 1), ref_px(r, c, md), 1);
        if (n == 0) mode = 2'($urandom_range(0, 3));
        n++;
      end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && q.size() != 0; k++) @(posedge clk);
    chk("drain_empty", q.size(), 0);
    idle(3);
  endtask

  task automatic clear_img();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 0;
  endtask

  task automatic rand_img(input int dens);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img[r][c] = ($urandom_range(0, 99) < dens);
  endtask

  initial begin
    bit px;
    repeat (3) @(posedge clk); #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_tready", s_tready, 1);
    aresetn = 1'b1;
    idle(2);

    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) img[r][c] = bit'((r + c) & 1);
    lat_arm = 1;
    send_frame(8, 4, 0, 0, -1);
    drain();
    chk("pass_line_err", line_err, 0);

    clear_img(); img[4][4] = 1; ones = 0;
    send_frame(8, 8, 1, 1, -1);
    drain();
    chk("erode_ones", ones, 0);

    rdy_mode = 1; ones = 0; cnt0 = out_cnt;
    send_frame(8, 8, 2, 0, -1);
    drain();
    chk("dilate_ones", ones, 9);
    chk("dilate_count", out_cnt - cnt0, 64);
    rdy_mode = 0;

    clear_img();
    for (int r = 2; r < 5; r++) for (int c = 2; c < 5; c++) img[r][c] = 1;
    img[0][7] = 1; img[7][0] = 1;
    send_frame(8, 8, 3, 1, -1);
    drain();

    // Second line ends at column 5 of an 8-wide frame.
    mode = 2'd0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 1) ? 6 : 8); c++) begin
        px = bit'($urandom_range(0, 1));
        beat(px, (r == 0 && c == 0), (c == ((r == 1) ? 5 : 7)), px, 1);
      end
    drain();
    chk("short_line_err", line_err, 1);
    rand_img(50);
    send_frame(8, 2, 0, 0, -1);
    drain();
    chk("err_cleared_sof", line_err, 0);

    // Line longer than MAX_WIDTH.
    mode = 2'd0;
    for (int i = 0; i < MW + 2; i++) begin
      px = bit'($urandom_range(0, 1));
      beat(px, (i == 0), (i == MW + 1), px, 1);
    end
    drain();
    chk("overflow_err", line_err, 1);
    send_frame(8, 2, 0, 0, -1);
    drain();
    chk("overflow_cleared", line_err, 0);

    // Reset mid-frame, then beats without SOF must be dropped.
    rand_img(50);
    send_frame(6, 6, 2, 0, 10);
    aresetn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    q.delete();
    chk("midrst_tvalid", m_tvalid, 0);
    aresetn = 1'b1;
    cnt0 = out_cnt;
    for (int i = 0; i < 6; i++) beat(bit'($urandom_range(0, 1)), 0, (i % 3 == 2), 0, 0);
    idle(6);
    chk("no_out_wo_sof", out_cnt - cnt0, 0);
    rand_img(50);
    send_frame(5, 4, 3, 1, -1);
    drain();

    rdy_mode = 2;
    for (int it = 0; it < 25; it++) begin
      rand_img($urandom_range(20, 80));
      send_frame($urandom_range(1, MW), $urandom_range(1, 6), $urandom_range(0, 3), 2, -1);
    end
    drain();
    chk("random_line_err", line_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
